mult_div_unit: RTL and testbench

- Iterative multiply/divide unit downstream of the register file.
- Consumes the RS/RT operand pair read for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers.
- HI/LO feed the MFHI/MFLO write-back mux into the register file.
- Multi-cycle block; control holds the pipeline while busy_o is high.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_divider.sv | 63 ++++++
 rtl/mult_div_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type, default widths and small opcode decode helpers.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;
  localparam int MDU_CNT_W  = 6;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // Divide operations have the upper opcode bit set.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed operations have the lower opcode bit clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider datapath for mult_div_unit. Works on magnitudes only;
// sign handling and the divide-by-zero result are applied by the top level.
// One quotient bit is produced per 'step' pulse, MSB first.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero
);

  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] dvs_r;
  logic [DATA_W:0]   shifted_s;
  logic [DATA_W:0]   diff_s;
  logic              fits_s;

  // Trial subtraction of the divisor from the partial remainder shifted left by one.
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_W-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    fits_s    = ~diff_s[DATA_W];
  end

  // Remainder/quotient shift registers: load operands, then one restoring step per pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rem_r <= {DATA_W{1'b0}};
      quo_r <= {DATA_W{1'b0}};
      dvs_r <= {DATA_W{1'b0}};
    end else if (load) begin
      rem_r <= {DATA_W{1'b0}};
      quo_r <= dividend;
      dvs_r <= divisor;
    end else if (step) begin
      if (fits_s) begin
        rem_r <= diff_s[DATA_W-1:0];
        quo_r <= {quo_r[DATA_W-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[DATA_W-1:0];
        quo_r <= {quo_r[DATA_W-2:0], 1'b0};
      end
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
      dvs_r <= dvs_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign div_zero  = (dvs_r == {DATA_W{1'b0}});

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use a shift-add loop in this module; DIV/DIVU use mdu_divider.
// Optional build macro MDU_FAST_MULT_EN: multiplies finish with a single-cycle
// multiplier in CALC (done after edge 2); divides are unaffected.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = MDU_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              mthi_i,
  input  logic              mtlo_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  mdu_state_e          state_r;
  mdu_state_e          state_next_s;
  logic                accept_s;
  logic                step_s;
  logic                fix_s;
  logic                move_ok_s;
  logic                last_step_s;

  logic [1:0]          op_r;
  logic                sign_a_r;
  logic                sign_b_r;
  logic [DATA_W-1:0]   mcand_r;
  logic [2*DATA_W-1:0] prod_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic                busy_r;
  logic                done_r;

  logic                a_neg_s;
  logic                b_neg_s;
  logic [DATA_W-1:0]   a_abs_s;
  logic [DATA_W-1:0]   b_abs_s;
  logic [2*DATA_W-1:0] mult_next_s;
  logic [2*DATA_W-1:0] prod_fix_s;
  logic [DATA_W-1:0]   res_hi_s;
  logic [DATA_W-1:0]   res_lo_s;

  logic [DATA_W-1:0]   div_quo_s;
  logic [DATA_W-1:0]   div_rem_s;
  logic                div_zero_s;

  // Operand magnitudes and signs for the request currently on the inputs.
  always_comb begin
    a_neg_s = op_is_signed(op_i) & rs_data_i[DATA_W-1];
    b_neg_s = op_is_signed(op_i) & rt_data_i[DATA_W-1];
    a_abs_s = a_neg_s ? -rs_data_i : rs_data_i;
    b_abs_s = b_neg_s ? -rt_data_i : rt_data_i;
  end

`ifdef MDU_FAST_MULT_EN
  // Full product in one cycle; multiplies leave CALC after a single step.
  always_comb begin
    mult_next_s = (2*DATA_W)'(mcand_r) * (2*DATA_W)'(prod_r[DATA_W-1:0]);
    if (op_is_div(op_r)) begin
      last_step_s = (cnt_r == LAST_CNT);
    end else begin
      last_step_s = 1'b1;
    end
  end
`else
  logic [DATA_W:0] mult_sum_s;

  // Shift-add step: the multiplier sits in the low half of prod_r and is consumed LSB first.
  always_comb begin
    if (prod_r[0]) begin
      mult_sum_s = {1'b0, prod_r[2*DATA_W-1:DATA_W]} + {1'b0, mcand_r};
    end else begin
      mult_sum_s = {1'b0, prod_r[2*DATA_W-1:DATA_W]};
    end
    mult_next_s = {mult_sum_s, prod_r[DATA_W-1:1]};
    last_step_s = (cnt_r == LAST_CNT);
  end
`endif

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    fix_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          accept_s     = 1'b1;
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        step_s = 1'b1;
        if (last_step_s) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_FIX: begin
        fix_s        = 1'b1;
        state_next_s = ST_DONE;
      end
      ST_DONE: begin
        if (start_i) begin
          accept_s     = 1'b1;
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Register moves are allowed only when idle and no start competes for the cycle.
  always_comb begin
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      move_ok_s = ~start_i;
    end else begin
      move_ok_s = 1'b0;
    end
  end

  // Sign correction and result mapping applied in FIX.
  always_comb begin
    if (sign_a_r ^ sign_b_r) begin
      prod_fix_s = -prod_r;
    end else begin
      prod_fix_s = prod_r;
    end
    if (op_is_div(op_r)) begin
      if (div_zero_s) begin
        // mcand_r holds |A|; restoring the sign gives back A as captured.
        res_lo_s = {DATA_W{1'b1}};
        res_hi_s = sign_a_r ? -mcand_r : mcand_r;
      end else begin
        res_lo_s = (sign_a_r ^ sign_b_r) ? -div_quo_s : div_quo_s;
        res_hi_s = sign_a_r ? -div_rem_s : div_rem_s;
      end
    end else begin
      res_hi_s = prod_fix_s[2*DATA_W-1:DATA_W];
      res_lo_s = prod_fix_s[DATA_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, iteration counter and multiply working register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_r     <= 2'b00;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      mcand_r  <= {DATA_W{1'b0}};
      prod_r   <= {(2*DATA_W){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      op_r     <= op_i;
      sign_a_r <= a_neg_s;
      sign_b_r <= b_neg_s;
      mcand_r  <= a_abs_s;
      prod_r   <= {{DATA_W{1'b0}}, b_abs_s};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (step_s) begin
      cnt_r <= cnt_r + CNT_ONE;
      if (!op_is_div(op_r)) begin
        prod_r <= mult_next_s;
      end else begin
        prod_r <= prod_r;
      end
    end else begin
      cnt_r  <= cnt_r;
      prod_r <= prod_r;
    end
  end

  // Architectural HI/LO: final result on FIX->DONE, otherwise MTHI/MTLO when allowed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hi_r <= {DATA_W{1'b0}};
      lo_r <= {DATA_W{1'b0}};
    end else if (fix_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if (move_ok_s) begin
      hi_r <= mthi_i ? rs_data_i : hi_r;
      lo_r <= mtlo_i ? rs_data_i : lo_r;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Registered status outputs derived from the upcoming state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  mdu_divider #(
    .DATA_W (DATA_W)
  ) u_divider (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (accept_s),
    .step      (step_s & op_is_div(op_r)),
    .dividend  (a_abs_s),
    .divisor   (b_abs_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s),
    .div_zero  (div_zero_s)
  );

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences (busy-time inputs, moves, async reset) and random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  rs_data_i;
  logic [W-1:0]  rt_data_i;
  logic          mthi_i;
  logic          mtlo_i;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .mthi_i    (mthi_i),
    .mtlo_i    (mtlo_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'h0;
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Edge count from the start edge to done_o high.
  function automatic int exp_lat(input logic [1:0] op);
`ifdef MDU_FAST_MULT_EN
    if (op[1] == 1'b0) return 2;
`endif
    return W + 1;
  endfunction

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done_o && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit tail, input string name);
    int edges;
    logic [63:0] r;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
    @(posedge clk);
    #1;
    check({name, ".busy"}, 64'(busy_o), 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    wait_done(edges);
    check({name, ".latency"}, 64'(edges), 64'(exp_lat(op)));
    r = ref_calc(op, a, b);
    check({name, ".hi"}, 64'(hi_o), 64'(r[63:32]));
    check({name, ".lo"}, 64'(lo_o), 64'(r[31:0]));
    if (tail) begin
      @(posedge clk);
      #1;
      check({name, ".done_low"}, 64'(done_o), 64'd0);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int edges;
    int pulses;
    int done_edge;
    logic [1:0] busy_op;
    logic [W-1:0] busy_a, busy_b;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A};
    vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

    rst_i = 1'b0; start_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
    mthi_i = 1'b0; mtlo_i = 1'b0;
    #12;
    check("reset.busy", 64'(busy_o), 64'd0);
    check("reset.done", 64'(done_o), 64'd0);
    check("reset.hi", 64'(hi_o), 64'd0);
    check("reset.lo", 64'(lo_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b1;

    // Directed table; vector 0 leaves the unit in DONE so vector 1 starts back-to-back.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_i = 1'b1; op_i = vecs[i].op; rs_data_i = vecs[i].a; rt_data_i = vecs[i].b;
      @(posedge clk);
      #1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(edges);
      check($sformatf("vec%0d.latency", i), 64'(edges), 64'(exp_lat(vecs[i].op)));
      check($sformatf("vec%0d.hi", i), 64'(hi_o), 64'(vecs[i].hi));
      check($sformatf("vec%0d.lo", i), 64'(lo_o), 64'(vecs[i].lo));
      if (i != 0) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d.done_low", i), 64'(done_o), 64'd0);
      end
    end

    // Start and MTHI while busy are both ignored.
`ifdef MDU_FAST_MULT_EN
    busy_op = 2'b11; busy_a = 32'd12; busy_b = 32'd1;
`else
    busy_op = 2'b01; busy_a = 32'd3; busy_b = 32'd4;
`endif
    @(negedge clk);
    start_i = 1'b1; op_i = busy_op; rs_data_i = busy_a; rt_data_i = busy_b;
    @(posedge clk);
    pulses = 0;
    done_edge = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      start_i = (e == 5);
      op_i = 2'b11;
      mthi_i = (e == 6);
      rs_data_i = (e == 6) ? 32'hAA : 32'd9;
      rt_data_i = 32'd2;
      @(posedge clk);
      #1;
      if (done_o) begin
        pulses++;
        done_edge = e;
      end
    end
    @(negedge clk);
    mthi_i = 1'b0;
    check("busy.pulses", 64'(pulses), 64'd1);
    check("busy.done_edge", 64'(done_edge), 64'(W + 1));
    check("busy.hi", 64'(hi_o), 64'd0);
    check("busy.lo", 64'(lo_o), 64'd12);

    // Moves in IDLE, single move, and start winning over a move.
    @(negedge clk);
    mthi_i = 1'b1; mtlo_i = 1'b1; rs_data_i = 32'h1234;
    @(posedge clk);
    #1;
    check("move.hi", 64'(hi_o), 64'h1234);
    check("move.lo", 64'(lo_o), 64'h1234);
    @(negedge clk);
    mthi_i = 1'b0; mtlo_i = 1'b1; rs_data_i = 32'h55;
    @(posedge clk);
    #1;
    check("mtlo.hi", 64'(hi_o), 64'h1234);
    check("mtlo.lo", 64'(lo_o), 64'h55);
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; rs_data_i = 32'd2; rt_data_i = 32'd3;
    mthi_i = 1'b1; mtlo_i = 1'b1;
    @(posedge clk);
    #1;
    check("startwins.hi", 64'(hi_o), 64'h1234);
    check("startwins.lo", 64'(lo_o), 64'h55);
    @(negedge clk);
    start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
    wait_done(edges);
    check("startwins.result", 64'({hi_o, lo_o}), 64'd6);

    // Async reset in the middle of a divide.
    @(posedge clk);
    #1;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; rs_data_i = 32'd100; rt_data_i = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int e = 1; e <= 10; e++) @(posedge clk);
    #1;
    check("prereset.busy", 64'(busy_o), 64'd1);
    rst_i = 1'b0;
    #1;
    check("asyncrst.busy", 64'(busy_o), 64'd0);
    check("asyncrst.done", 64'(done_o), 64'd0);
    check("asyncrst.hi", 64'(hi_o), 64'd0);
    check("asyncrst.lo", 64'(lo_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b1;
    run_op(2'b10, 32'd100, 32'd7, 1'b1, "postrst");

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b1,
             $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
